// File: rtl/ureg_xfer_ctrl_if.sv
// rtl/ureg_xfer_ctrl_if.sv - command/response, serial link and register pins of the transfer controller
`timescale 1ns/1ps
interface ureg_xfer_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;
  logic             ser_out;
  logic             ser_out_valid;
  logic             ser_out_ready;
  logic             ser_in;
  logic             ser_in_valid;
  logic             ser_in_ready;
  logic             reg_enable;
  logic [1:0]       reg_mode;
  logic             reg_load;
  logic             reg_serial_in;
  logic [WIDTH-1:0] reg_parallel_in;
  logic             reg_serial_out;
  logic [WIDTH-1:0] reg_parallel_out;
  logic             reg_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, ser_out_ready, ser_in, ser_in_valid,
           reg_serial_out, reg_parallel_out, reg_err,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ser_out, ser_out_valid,
           ser_in_ready, reg_enable, reg_mode, reg_load, reg_serial_in, reg_parallel_in
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, ser_out_ready, ser_in, ser_in_valid,
           reg_serial_out, reg_parallel_out, reg_err,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ser_out, ser_out_valid,
           ser_in_ready, reg_enable, reg_mode, reg_load, reg_serial_in, reg_parallel_in
  );
endinterface

// File: rtl/ureg_xfer_ctrl.sv
// rtl/ureg_xfer_ctrl.sv - sequences write/read/serialize/deserialize commands on a universal shift register
`timescale 1ns/1ps
module ureg_xfer_ctrl #(
  parameter int   WIDTH   = 4,
  parameter logic TX_FILL = 1'b0
) (
  input logic             clk,
  input logic             rst,
  ureg_xfer_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_SER_TX = 2'b10;
  localparam logic [1:0] OP_SER_RX = 2'b11;

  localparam logic [1:0] MODE_SIPO = 2'b01;
  localparam logic [1:0] MODE_PISO = 2'b10;
  localparam logic [1:0] MODE_PIPO = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic shift_tx;
  logic shift_rx;
  logic shift_hs;

  assign shift_tx = (state_q == S_SHIFT) && (op_q == OP_SER_TX);
  assign shift_rx = (state_q == S_SHIFT) && (op_q == OP_SER_RX);
  assign shift_hs = (shift_tx && bus.ser_out_ready) || (shift_rx && bus.ser_in_valid);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = bus.cmd_op;
          data_d     = bus.cmd_data;
          cnt_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (bus.cmd_op)
            OP_READ:   state_d = S_CAPTURE;
            OP_SER_RX: state_d = S_SHIFT;
            default:   state_d = S_LOAD;
          endcase
        end
      end
      S_LOAD:    state_d = (op_q == OP_SER_TX) ? S_SHIFT : S_RESP;
      S_SHIFT: begin
        // Stalled cycles leave the count untouched; only accepted bits advance it.
        if (shift_hs) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = (op_q == OP_SER_TX) ? S_RESP : S_CAPTURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        rsp_data_d = bus.reg_parallel_out;
        rsp_err_d  = bus.reg_err;
        state_d    = S_RESP;
      end
      S_RESP:    if (bus.rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_WRITE;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Pin drive is decoded from registered state; reset forces every pin low in the same cycle.
  always_comb begin
    bus.cmd_ready       = 1'b0;
    bus.rsp_valid       = 1'b0;
    bus.rsp_data        = '0;
    bus.rsp_err         = 1'b0;
    bus.busy            = 1'b0;
    bus.ser_out         = 1'b0;
    bus.ser_out_valid   = 1'b0;
    bus.ser_in_ready    = 1'b0;
    bus.reg_enable      = 1'b0;
    bus.reg_mode        = 2'b00;
    bus.reg_load        = 1'b0;
    bus.reg_serial_in   = 1'b0;
    bus.reg_parallel_in = '0;
    if (!rst) begin
      bus.busy     = (state_q != S_IDLE);
      bus.rsp_data = rsp_data_q;
      bus.rsp_err  = rsp_err_q;
      case (state_q)
        S_IDLE:  bus.cmd_ready = 1'b1;
        S_LOAD: begin
          bus.reg_enable      = 1'b1;
          bus.reg_load        = 1'b1;
          bus.reg_parallel_in = data_q;
          bus.reg_mode        = (op_q == OP_SER_TX) ? MODE_PISO : MODE_PIPO;
        end
        S_SHIFT: begin
          if (op_q == OP_SER_TX) begin
            bus.reg_mode      = MODE_PISO;
            bus.reg_serial_in = TX_FILL;
            bus.ser_out_valid = 1'b1;
            bus.ser_out       = bus.reg_serial_out;
            bus.reg_enable    = bus.ser_out_ready;
          end else begin
            bus.reg_mode      = MODE_SIPO;
            bus.reg_serial_in = bus.ser_in;
            bus.ser_in_ready  = 1'b1;
            bus.reg_enable    = bus.ser_in_valid;
          end
        end
        S_RESP:  bus.rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ureg_xfer_ctrl.sv
// tb/tb_ureg_xfer_ctrl.sv - directed bench for ureg_xfer_ctrl with a behavioural shift register
`timescale 1ns/1ps
module tb_ureg_xfer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic       err_force = 1'b0;
  logic [3:0] rq;
  logic [3:0] got;
  logic [3:0] rdata;
  logic       rerr;
  int         wait_n;

  always #5 clk = ~clk;

  ureg_xfer_ctrl_if #(.WIDTH(4)) bus ();

  ureg_xfer_ctrl #(.WIDTH(4), .TX_FILL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shift-right register: serial_in enters the MSB, serial_out is bit 0.
  always @(posedge clk) begin
    if (bus.reg_enable)
      rq <= bus.reg_load ? bus.reg_parallel_in : {bus.reg_serial_in, rq[3:1]};
  end
  assign bus.reg_serial_out   = rq[0];
  assign bus.reg_parallel_out = rq;
  assign bus.reg_err          = err_force;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, output logic [3:0] d, output logic e);
    wait_n = 0;
    while (!bus.rsp_valid && wait_n < 50) begin
      tick();
      wait_n++;
    end
    chk1({tag, "_rsp_seen"}, bus.rsp_valid, 1'b1);
    d = bus.rsp_data;
    e = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_op        = 2'b00;
    bus.cmd_data      = 4'b0000;
    bus.rsp_ready     = 1'b0;
    bus.ser_out_ready = 1'b0;
    bus.ser_in        = 1'b0;
    bus.ser_in_valid  = 1'b0;

    tick();
    tick();
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_reg_enable", bus.reg_enable, 1'b0);
    rst = 1'b0;
    #1;
    chk1("idle_cmd_ready", bus.cmd_ready, 1'b1);

    // WRITE 1110 then READ
    issue(2'b00, 4'b1110);
    chkv("wr_mode", {2'b00, bus.reg_mode}, 4'b0011);
    chk1("wr_load", bus.reg_load, 1'b1);
    chk1("wr_enable", bus.reg_enable, 1'b1);
    chkv("wr_pin", bus.reg_parallel_in, 4'b1110);
    chk1("wr_busy", bus.busy, 1'b1);
    chk1("wr_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    chk1("wr_rsp_t2", bus.rsp_valid, 1'b1);
    chk1("wr_load_one_cycle", bus.reg_load, 1'b0);
    chkv("wr_rsp_data", bus.rsp_data, 4'b0000);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk1("wr_done_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("wr_done_cmd_ready", bus.cmd_ready, 1'b1);

    issue(2'b01, 4'b0000);
    chk1("rd_capture_enable", bus.reg_enable, 1'b0);
    chk1("rd_capture_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    chk1("rd_rsp_t2", bus.rsp_valid, 1'b1);
    chkv("rd_rsp_data", bus.rsp_data, 4'b1110);
    chk1("rd_rsp_err", bus.rsp_err, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // SER_TX 1011, sink always ready
    bus.ser_out_ready = 1'b1;
    issue(2'b10, 4'b1011);
    chkv("tx_load_mode", {2'b00, bus.reg_mode}, 4'b0010);
    chk1("tx_load_load", bus.reg_load, 1'b1);
    chk1("tx_load_no_valid", bus.ser_out_valid, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk1("tx_valid", bus.ser_out_valid, 1'b1);
      chk1("tx_enable", bus.reg_enable, 1'b1);
      got[i] = bus.ser_out;
      tick();
    end
    chkv("tx_bits", got, 4'b1011);
    chk1("tx_rsp_t6", bus.rsp_valid, 1'b1);
    chkv("tx_rsp_data", bus.rsp_data, 4'b0000);
    chk1("tx_rsp_no_ser_valid", bus.ser_out_valid, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // SER_TX 1011 with a 3-cycle stall on the second bit
    issue(2'b10, 4'b1011);
    tick();
    got[0] = bus.ser_out;
    tick();
    bus.ser_out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1("stall_ser_out", bus.ser_out, 1'b1);
      chk1("stall_valid", bus.ser_out_valid, 1'b1);
      chk1("stall_enable", bus.reg_enable, 1'b0);
      tick();
    end
    bus.ser_out_ready = 1'b1;
    #1;
    for (int i = 1; i < 4; i++) begin
      got[i] = bus.ser_out;
      tick();
    end
    chkv("stall_bits", got, 4'b1011);
    chk1("stall_rsp_valid", bus.rsp_valid, 1'b1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.ser_out_ready = 1'b0;

    // SER_RX bits 1,0,0,1 with valid gaps
    issue(2'b11, 4'b0000);
    chkv("rx_mode", {2'b00, bus.reg_mode}, 4'b0001);
    chk1("rx_in_ready", bus.ser_in_ready, 1'b1);
    chk1("rx_no_ser_out_valid", bus.ser_out_valid, 1'b0);
    bus.ser_in_valid = 1'b1; bus.ser_in = 1'b1; tick();
    bus.ser_in_valid = 1'b0; bus.ser_in = 1'b0; #1;
    chk1("rx_gap_enable", bus.reg_enable, 1'b0);
    tick();
    bus.ser_in_valid = 1'b1; bus.ser_in = 1'b0; tick();
    bus.ser_in_valid = 1'b0; bus.ser_in = 1'b0; tick();
    bus.ser_in_valid = 1'b0; bus.ser_in = 1'b1; tick();
    bus.ser_in_valid = 1'b1; bus.ser_in = 1'b0; tick();
    chk1("rx_not_done_early", bus.ser_in_ready, 1'b1);
    bus.ser_in_valid = 1'b1; bus.ser_in = 1'b1; tick();
    bus.ser_in_valid = 1'b0; bus.ser_in = 1'b0;
    chkv("rx_capture_mode", {2'b00, bus.reg_mode}, 4'b0000);
    chk1("rx_capture_in_ready", bus.ser_in_ready, 1'b0);
    chk1("rx_capture_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    chk1("rx_rsp_valid", bus.rsp_valid, 1'b1);
    chkv("rx_rsp_data", bus.rsp_data, 4'b1001);
    chk1("rx_rsp_err", bus.rsp_err, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // READ with ECC error during capture, then hold the response
    issue(2'b01, 4'b0000);
    err_force = 1'b1;
    tick();
    err_force = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk1("hold_rsp_err", bus.rsp_err, 1'b1);
      chkv("hold_rsp_data", bus.rsp_data, 4'b1001);
      chk1("hold_cmd_ready", bus.cmd_ready, 1'b0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk1("hold_done_cmd_ready", bus.cmd_ready, 1'b1);

    // Reset during SER_TX after two bits
    bus.ser_out_ready = 1'b1;
    issue(2'b10, 4'b1011);
    tick();
    tick();
    tick();
    chk1("abort_pre_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("abort_in_rst_valid", bus.ser_out_valid, 1'b0);
    chk1("abort_in_rst_enable", bus.reg_enable, 1'b0);
    tick();
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_cmd_ready", bus.cmd_ready, 1'b0);
    chk1("abort_ser_out", bus.ser_out, 1'b0);
    chk1("abort_ser_out_valid", bus.ser_out_valid, 1'b0);
    chk1("abort_reg_enable", bus.reg_enable, 1'b0);
    chk1("abort_rsp_valid", bus.rsp_valid, 1'b0);
    rst = 1'b0;
    bus.ser_out_ready = 1'b0;
    #1;
    chk1("post_rst_idle_ready", bus.cmd_ready, 1'b1);
    chk1("post_rst_no_rsp", bus.rsp_valid, 1'b0);
    chk1("post_rst_not_busy", bus.busy, 1'b0);

    issue(2'b00, 4'b0101);
    get_rsp("post_wr", rdata, rerr);
    chkv("post_wr_data", rdata, 4'b0000);
    issue(2'b01, 4'b0000);
    get_rsp("post_rd", rdata, rerr);
    chkv("post_rd_data", rdata, 4'b0101);
    chk1("post_rd_err", rerr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ureg_xfer_ctrl.md
Name: ureg_xfer_ctrl

Overview:
Transaction controller that sequences the universal shift register (modes SISO/SIPO/PISO/PIPO, Hamming-protected storage) on behalf of a single command master.
- Accepts write / read / serialize / deserialize commands over a valid/ready interface.
- Drives the register's enable/mode/load/data pins and moves bits over a stallable serial link.
- Returns one response per command: read data plus the register's ECC error flag.

Parameters:
WIDTH, 4, register width in bits; also the shift count per serial transfer.
TX_FILL, 1'b0, value driven on reg_serial_in during serialize shifts.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 WRITE, 01 READ, 10 SER_TX, 11 SER_RX
cmd_data  in  WIDTH  parallel data for WRITE / SER_TX
rsp_valid  out  1  response present
rsp_ready  in  1  master accepts response
rsp_data  out  WIDTH  captured register value (READ/SER_RX), else 0
rsp_err  out  1  reg_err sampled at capture (READ/SER_RX), else 0
busy  out  1  state != IDLE
ser_out  out  1  serialized bit (= reg_serial_out)
ser_out_valid  out  1  ser_out carries a valid bit
ser_out_ready  in  1  serial sink accepts bit
ser_in  in  1  deserialize input bit
ser_in_valid  in  1  ser_in carries a valid bit
ser_in_ready  out  1  controller consumes ser_in this cycle
reg_enable  out  1  to register enable
reg_mode  out  2  to register mode: 00 SISO, 01 SIPO, 10 PISO, 11 PIPO
reg_load  out  1  to register parallel load
reg_serial_in  out  1  to register serial input
reg_parallel_in  out  WIDTH  to register parallel input
reg_serial_out  in  1  from register serial output
reg_parallel_out  in  WIDTH  from register parallel output
reg_err  in  1  ECC error flag from register

Behaviour:
Register model:
- Updates on clk when reg_enable=1.
- Shifts right: serial_in enters bit WIDTH-1; serial_out = bit 0.

States and transitions:
- IDLE: cmd_ready=1 (forced 0 while rst). On cmd_valid&cmd_ready, latch op/data. Next state: WRITE->LOAD, READ->CAPTURE, SER_TX->LOAD, SER_RX->SHIFT. The shift counter is cleared.
- LOAD (1 cycle): reg_enable=1, reg_load=1, reg_parallel_in=latched data. reg_mode=11 for WRITE, 10 for SER_TX. Next: WRITE->RESP, SER_TX->SHIFT.
- SHIFT, SER_TX:
  - reg_mode=10, reg_load=0, reg_serial_in=TX_FILL.
  - ser_out_valid=1, ser_out=reg_serial_out.
  - reg_enable = ser_out_ready.
- SHIFT, SER_RX:
  - reg_mode=01, reg_serial_in=ser_in.
  - ser_in_ready=1.
  - reg_enable = ser_in_valid.
- SHIFT counting: counter increments only on a handshake cycle. The WIDTH-th handshake exits: SER_TX->RESP, SER_RX->CAPTURE. A stall holds state and counter indefinitely.
- CAPTURE (1 cycle): reg_enable=0. Registers rsp_data<=reg_parallel_out and rsp_err<=reg_err. Next: RESP.
- RESP: rsp_valid=1. rsp_data and rsp_err are stable until rsp_ready. Then -> IDLE; cmd_ready reasserts on the next cycle, so there is no same-cycle re-accept.

Pin defaults:
- reg_enable=0 in IDLE, CAPTURE and RESP: register contents are frozen.
- ser_out_valid and ser_in_ready are 0 outside SHIFT of the matching op.

Latency with no stalls (accept edge = T; rsp_valid first high):
- WRITE: T+2.
- READ: T+2.
- SER_TX: T+2+WIDTH.
- SER_RX: T+2+WIDTH.

Reset:
- Synchronous. Aborts any operation; state returns to IDLE and the counter is cleared.
- All outputs are 0 during rst: cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ser_*, reg_*.
- Register contents after an abort are undefined; no response is issued for the aborted command.

Ordering and errors:
- Commands are strictly serialized; no pipelining.
- rsp_data and rsp_err are 0 for WRITE and SER_TX.
- reg_err is sampled only in CAPTURE; no retry is performed.

Test Plan:
1. WRITE 4'b1110, then READ -> reg_mode=11/reg_load=1 for exactly one cycle; READ rsp_data=4'b1110, rsp_err=0, rsp_valid at T+2.
2. SER_TX 4'b1011 with ser_out_ready=1 -> ser_out sequence 1,1,0,1 over 4 consecutive cycles; rsp_valid at T+6, rsp_data=0.
3. SER_TX 4'b1011 with ser_out_ready low on the 2nd bit for 3 cycles -> ser_out holds 1 and the counter holds during the stall; full sequence still 1,1,0,1; reg_enable low during the stall.
4. SER_RX with ser_in bits 1,0,0,1 (ser_in_valid gaps included) -> rsp_data=4'b1001 after 4 handshakes; SIPO mode only during SHIFT.
5. Force reg_err=1 during CAPTURE of a READ -> rsp_err=1, rsp_data = register value. Hold rsp_ready=0 for 5 cycles -> rsp held; cmd_ready stays 0.
6. Assert rst during SER_TX after 2 bits -> next cycle all outputs 0 and state IDLE. A new WRITE 4'b0101 after reset completes normally.
